// File: rtl/cpu_pkg.sv
// cpu_pkg: shared definitions for the 4-bit CPU control path.
//   - opcode constants (IR[7:6]) and ALU op encodings
//   - instruction field bit positions
//   - FSM state encoding (STEP_WAIT exists only with CU_SINGLE_STEP_EN)
package cpu_pkg;

  localparam logic [1:0] OP_LDI = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_CTL = 2'b11;

  localparam logic ALU_ADD = 1'b0;
  localparam logic ALU_SUB = 1'b1;

  // Field LSB positions; all register fields are 2 bits, IMM is 4 bits.
  localparam int OPC_LSB = 6;
  localparam int W_LSB   = 4;
  localparam int A_LSB   = 2;
  localparam int B_LSB   = 0;
  localparam int IMM_LSB = 0;
  localparam int HLT_BIT = 5;  // within OP_CTL: 0 = JMP, 1 = HLT

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_HALT  = 3'd3
`ifdef CU_SINGLE_STEP_EN
    ,
    S_STEP_WAIT = 3'd4
`endif
  } state_t;

endpackage

// File: rtl/instr_decode.sv
// instr_decode: combinational instruction decoder.
//   in : ir (8b instruction register), state (FSM state)
//   out: sel_a/sel_b/sel_w (2b), imm (4b), sel_data, alu_op, write_en,
//        is_jmp, is_hlt
// Register selects, IMM and alu_op follow IR in every state; write_en and
// sel_data are qualified by EXEC so a reset IR (0x00 = LDI) drives nothing.
module instr_decode
  import cpu_pkg::*;
(
  input  logic [7:0] ir,
  input  state_t     state,
  output logic [1:0] sel_a,
  output logic [1:0] sel_b,
  output logic [1:0] sel_w,
  output logic [3:0] imm,
  output logic       sel_data,
  output logic       alu_op,
  output logic       write_en,
  output logic       is_jmp,
  output logic       is_hlt
);

  logic [1:0] op;

  always_comb begin
    op       = ir[OPC_LSB +: 2];
    sel_w    = ir[W_LSB +: 2];
    sel_a    = ir[A_LSB +: 2];
    sel_b    = ir[B_LSB +: 2];
    imm      = ir[IMM_LSB +: 4];
    alu_op   = (op == OP_SUB) ? ALU_SUB : ALU_ADD;
    is_jmp   = (op == OP_CTL) && !ir[HLT_BIT];
    is_hlt   = (op == OP_CTL) &&  ir[HLT_BIT];
    write_en = (state == S_EXEC) && (op != OP_CTL);
    sel_data = write_en && (op == OP_LDI);
  end

endmodule

// File: rtl/control_unit.sv
// control_unit: FETCH/EXEC sequencer for the 4-bit datapath.
//   clk, rst (async, active high), run (level)
//   step   : only with CU_SINGLE_STEP_EN; releases STEP_WAIT each clock it is high
//   INSTR  : combinational ROM data at address PC
//   PC     : program counter / ROM address (PC_W bits, wraps)
//   SEL_A/SEL_B/SEL_W/IMM/sel_data/write_en/alu_op : datapath controls
//   busy   : FETCH/EXEC (and STEP_WAIT), halted : HALT
// Optional macro CU_SINGLE_STEP_EN adds the step input and STEP_WAIT state.
module control_unit
  import cpu_pkg::*;
#(
  parameter int PC_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
`ifdef CU_SINGLE_STEP_EN
  input  logic            step,
`endif
  input  logic [7:0]      INSTR,
  output logic [PC_W-1:0] PC,
  output logic [1:0]      SEL_A,
  output logic [1:0]      SEL_B,
  output logic [1:0]      SEL_W,
  output logic [3:0]      IMM,
  output logic            sel_data,
  output logic            write_en,
  output logic            alu_op,
  output logic            busy,
  output logic            halted
);

`ifdef CU_SINGLE_STEP_EN
  localparam state_t AFTER_EXEC = S_STEP_WAIT;
`else
  localparam state_t AFTER_EXEC = S_FETCH;
`endif

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [7:0]      ir_q, ir_d;
  logic            is_jmp, is_hlt;

  instr_decode u_dec (
    .ir       (ir_q),
    .state    (state_q),
    .sel_a    (SEL_A),
    .sel_b    (SEL_B),
    .sel_w    (SEL_W),
    .imm      (IMM),
    .sel_data (sel_data),
    .alu_op   (alu_op),
    .write_en (write_en),
    .is_jmp   (is_jmp),
    .is_hlt   (is_hlt)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    case (state_q)
      S_IDLE:  if (run) state_d = S_FETCH;
      S_FETCH: begin
        ir_d    = INSTR;
        state_d = S_EXEC;
      end
      S_EXEC: begin
        pc_d = pc_q + PC_W'(1);  // natural wrap at 2**PC_W
        if (is_hlt) begin
          state_d = S_HALT;
        end else begin
          if (is_jmp) pc_d = ir_q[PC_W-1:0];
          state_d = AFTER_EXEC;
        end
      end
      // Leaving HALT needs run low first, so a held run does not re-launch.
      S_HALT:  if (!run) state_d = S_IDLE;
`ifdef CU_SINGLE_STEP_EN
      S_STEP_WAIT: if (step) state_d = S_FETCH;
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      ir_q    <= 8'h00;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    PC     = pc_q;
    halted = (state_q == S_HALT);
`ifdef CU_SINGLE_STEP_EN
    busy   = (state_q == S_FETCH) || (state_q == S_EXEC) || (state_q == S_STEP_WAIT);
`else
    busy   = (state_q == S_FETCH) || (state_q == S_EXEC);
`endif
  end

endmodule

// File: tb/tb_control_unit.sv
module tb_control_unit;
  localparam int PC_W  = 4;
  localparam int DEPTH = 1 << PC_W;

  logic            clk = 1'b0;
  logic            rst, run, step;
  logic [7:0]      rom [DEPTH];
  logic [PC_W-1:0] PC;
  logic [1:0]      SEL_A, SEL_B, SEL_W;
  logic [3:0]      IMM;
  logic            sel_data, write_en, alu_op, busy, halted;
  wire  [7:0]      INSTR = rom[PC];

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  control_unit #(.PC_W(PC_W)) dut (
    .clk(clk), .rst(rst), .run(run),
`ifdef CU_SINGLE_STEP_EN
    .step(step),
`endif
    .INSTR(INSTR), .PC(PC), .SEL_A(SEL_A), .SEL_B(SEL_B), .SEL_W(SEL_W),
    .IMM(IMM), .sel_data(sel_data), .write_en(write_en), .alu_op(alu_op),
    .busy(busy), .halted(halted)
  );

  task automatic chk(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
    end
  endtask

  // Behavioural model: phase 0 idle, 1 fetch, 2 execute, 3 halted, 4 waiting for step.
  int mph = 0;
  int mpc = 0;
  int mir = 0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mph = 0; mpc = 0; mir = 0;
    end else begin
      case (mph)
        0: if (run) mph = 1;
        1: begin mir = rom[mpc]; mph = 2; end
        2: begin
          int nxt;
`ifdef CU_SINGLE_STEP_EN
          nxt = 4;
`else
          nxt = 1;
`endif
          if (mir / 64 == 3 && (mir / 32) % 2 == 1) begin
            mpc = (mpc + 1) % DEPTH; mph = 3;
          end else if (mir / 64 == 3) begin
            mpc = mir % DEPTH; mph = nxt;
          end else begin
            mpc = (mpc + 1) % DEPTH; mph = nxt;
          end
        end
        3: if (!run) mph = 0;
        4: if (step) mph = 1;
        default: mph = 0;
      endcase
    end
  end

  // Every-cycle compare against the model.
  always @(negedge clk) begin
    int op, we;
    op = mir / 64;
    we = (mph == 2 && op != 3) ? 1 : 0;
    chk("pc",       PC,       mpc);
    chk("write_en", write_en, we);
    chk("sel_data", sel_data, (we == 1 && op == 0) ? 1 : 0);
    chk("sel_w",    SEL_W,    (mir / 16) % 4);
    chk("sel_a",    SEL_A,    (mir / 4) % 4);
    chk("sel_b",    SEL_B,    mir % 4);
    chk("imm",      IMM,      mir % 16);
    chk("alu_op",   alu_op,   (op == 2) ? 1 : 0);
    chk("busy",     busy,     (mph == 1 || mph == 2 || mph == 4) ? 1 : 0);
    chk("halted",   halted,   (mph == 3) ? 1 : 0);
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; run = 1'b0; step = 1'b1;
    for (int i = 0; i < DEPTH; i++) rom[i] = 8'hE0;
    rom[0] = 8'h27; rom[1] = 8'h4E; rom[2] = 8'h8E; rom[3] = 8'hC5;
    rom[5] = 8'hE0; rom[6] = 8'hC0;
    cyc(2);
    chk("rst_pc", PC, 0); chk("rst_we", write_en, 0);
    chk("rst_busy", busy, 0); chk("rst_halted", halted, 0);
    chk("rst_sel_data", sel_data, 0);
`ifndef CU_SINGLE_STEP_EN
    #1 rst = 1'b0; run = 1'b1;
    cyc(2);  // FETCH then EXEC of LDI R2,7
    chk("ldi_we", write_en, 1); chk("ldi_w", SEL_W, 2);
    chk("ldi_imm", IMM, 7); chk("ldi_sd", sel_data, 1);
    cyc(1);
    chk("ldi_pc", PC, 1); chk("ldi_we_off", write_en, 0);
    cyc(1);
    chk("add_we", write_en, 1); chk("add_w", SEL_W, 0); chk("add_a", SEL_A, 3);
    chk("add_b", SEL_B, 2); chk("add_sd", sel_data, 0); chk("add_op", alu_op, 0);
    cyc(2);
    chk("sub_we", write_en, 1); chk("sub_op", alu_op, 1); chk("sub_a", SEL_A, 3);
    cyc(2);
    chk("jmp_we", write_en, 0);
    cyc(1);
    chk("jmp_pc", PC, 5);
    run = 1'b0;  // ignored mid-program
    cyc(2);
    chk("hlt_halted", halted, 1); chk("hlt_busy", busy, 0); chk("hlt_pc", PC, 6);
    cyc(1);
    chk("idle_halted", halted, 0); chk("idle_pc", PC, 6);
    #1 run = 1'b1;
    cyc(1);
    chk("resume_busy", busy, 1); chk("resume_pc", PC, 6);
    cyc(2);
    chk("jmp0_pc", PC, 0);
    // PC wrap 15 -> 0
    #1 rst = 1'b1; rom[0] = 8'hCF; rom[15] = 8'h31;
    @(negedge clk); #1 rst = 1'b0;
    cyc(4);
    chk("wrap_pre_pc", PC, 15); chk("wrap_we", write_en, 1); chk("wrap_w", SEL_W, 3);
    cyc(1);
    chk("wrap_pc", PC, 0);
    // Reset during EXEC of an LDI aborts the write at once
    #1 rst = 1'b1; rom[0] = 8'h27;
    @(negedge clk); #1 rst = 1'b0;
    cyc(2);
    chk("abort_we_pre", write_en, 1);
    #1 rst = 1'b1;
    #1 chk("abort_we", write_en, 0); chk("abort_pc", PC, 0); chk("abort_busy", busy, 0);
    @(negedge clk);
`endif
    // Randomized phase
    for (int i = 0; i < DEPTH; i++) rom[i] = 8'($urandom);
    #1 rst = 1'b0; run = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk); #1;
      if (rst) rst = 1'b0;
      else if ($urandom_range(0, 249) == 0) rst = 1'b1;
      if ($urandom_range(0, 7) == 0) run = ~run;
      step = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 499) == 0)
        for (int i = 0; i < DEPTH; i++) rom[i] = 8'($urandom);
    end
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
